// File: rtl/uart_rx_if.sv
// uart_rx_if: serial-side inputs and parallel-side outputs of uart_rx.
//   slave  modport: the receiver itself.
//   master modport: whoever drives the line and consumes the results.
// Handshake: there is no ready; data_valid, par_err and stp_err are
// one-cycle strobes and the consumer must take P_DATA in the cycle
// data_valid is high (P_DATA then holds until the next good frame).
// state is a debug view of the receiver FSM:
//   0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP.
interface uart_rx_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  RX_IN;
   logic [5:0]            Prescale;
   logic                  parity_enable;
   logic                  parity_type;
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  data_valid;
   logic                  par_err;
   logic                  stp_err;
   logic                  busy;
   logic [2:0]            state;

   modport slave (
      input  RX_IN, Prescale, parity_enable, parity_type,
      output P_DATA, data_valid, par_err, stp_err, busy, state
   );

   modport master (
      output RX_IN, Prescale, parity_enable, parity_type,
      input  P_DATA, data_valid, par_err, stp_err, busy, state
   );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling asynchronous serial receiver (start, LSB-first data,
// optional parity, one stop bit). Prescale and parity settings are latched
// when the start edge is seen, so mid-frame changes are ignored.
// Optional build macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 majority
// of the samples at P/2-1, P/2, P/2+1 (resolved at P/2+2); without it a
// single sample at P/2 is used. Frame and strobe timing match in both builds.
module uart_rx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic     CLK,
   input  logic     RST,
   uart_rx_if.slave rx
);

   localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                state_q;
   logic [5:0]            edge_cnt_q;
   logic [BCW-1:0]        bit_cnt_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [DATA_WIDTH-1:0] p_data_q;
   logic                  data_valid_q;
   logic                  par_err_q;
   logic                  stp_err_q;
   logic                  busy_q;
   logic [5:0]            prescale_q;
   logic                  par_en_q;
   logic                  par_type_q;
   logic                  bit_q;       // resolved value of the current bit
   logic                  par_bad_q;   // parity mismatch seen, reported at stop
`ifdef UART_RX_MAJORITY_EN
   logic [2:0]            samp_q;
`endif

   logic [5:0] half_cnt;
   logic [5:0] last_cnt;
   logic       last_edge;

   assign half_cnt  = {1'b0, prescale_q[5:1]};
   assign last_cnt  = prescale_q - 6'd1;
   assign last_edge = (edge_cnt_q == last_cnt);

   // Frame FSM with bit sampling, counters and registered strobes.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= S_IDLE;
         edge_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         p_data_q     <= '0;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
         busy_q       <= 1'b0;
         prescale_q   <= '0;
         par_en_q     <= 1'b0;
         par_type_q   <= 1'b0;
         bit_q        <= 1'b0;
         par_bad_q    <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
         samp_q       <= '0;
`endif
      end else begin
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;

         if (state_q != S_IDLE) begin
            busy_q     <= 1'b1;
            edge_cnt_q <= last_edge ? 6'd0 : edge_cnt_q + 6'd1;
`ifdef UART_RX_MAJORITY_EN
            if (edge_cnt_q == half_cnt - 6'd1 || edge_cnt_q == half_cnt ||
                edge_cnt_q == half_cnt + 6'd1)
               samp_q <= {samp_q[1:0], rx.RX_IN};
            if (edge_cnt_q == half_cnt + 6'd2)
               bit_q <= (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                        (samp_q[1] & samp_q[2]);
`else
            if (edge_cnt_q == half_cnt)
               bit_q <= rx.RX_IN;
`endif
         end

         case (state_q)
            S_IDLE: begin
               // busy stays high one extra cycle after the stop bit, and
               // rises at the very edge that sees the start bit.
               busy_q     <= ~rx.RX_IN;
               edge_cnt_q <= '0;
               bit_cnt_q  <= '0;
               if (!rx.RX_IN) begin
                  state_q    <= S_START;
                  edge_cnt_q <= 6'd1;
                  prescale_q <= rx.Prescale;
                  par_en_q   <= rx.parity_enable;
                  par_type_q <= rx.parity_type;
                  par_bad_q  <= 1'b0;
               end
            end
            S_START: begin
               if (last_edge)
                  state_q <= bit_q ? S_IDLE : S_DATA;
            end
            S_DATA: begin
               if (last_edge) begin
                  shift_q <= {bit_q, shift_q[DATA_WIDTH-1:1]};
                  if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                     bit_cnt_q <= '0;
                     state_q   <= par_en_q ? S_PARITY : S_STOP;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end
            end
            S_PARITY: begin
               if (last_edge) begin
                  par_bad_q <= (bit_q != ((^shift_q) ^ par_type_q));
                  state_q   <= S_STOP;
               end
            end
            S_STOP: begin
               if (last_edge) begin
                  state_q <= S_IDLE;
                  if (!bit_q)
                     stp_err_q <= 1'b1;
                  if (par_bad_q)
                     par_err_q <= 1'b1;
                  if (bit_q && !par_bad_q) begin
                     p_data_q     <= shift_q;
                     data_valid_q <= 1'b1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rx.P_DATA     = p_data_q;
   assign rx.data_valid = data_valid_q;
   assign rx.par_err    = par_err_q;
   assign rx.stp_err    = stp_err_q;
   assign rx.busy       = busy_q;
   assign rx.state      = state_q;

endmodule
